// File: rtl/frog_controller.sv
// frog_controller: frog position, lives and top-of-screen tracking for Frogger.
//   Inputs : clk, rst_n (async, active-low), move_up/down/left/right (level
//            switches, a rising edge is one step), collision, reset_frog,
//            reset_lives.
//   Outputs: frog_x/frog_y (grid position), frog_at_top, lives, reset_level.
//   Optional: define FROG_WRAP_EN to wrap x at the left/right borders
//             instead of clamping (y is always clamped).
module frog_controller #(
  parameter int unsigned GRID_W     = 20,
  parameter int unsigned GRID_H     = 15,
  parameter int unsigned START_X    = 10,
  parameter int unsigned LIVES_INIT = 3,
  parameter int unsigned DEATH_CYC  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       move_up,
  input  logic       move_down,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       collision,
  input  logic       reset_frog,
  input  logic       reset_lives,
  output logic [4:0] frog_x,
  output logic [3:0] frog_y,
  output logic       frog_at_top,
  output logic [1:0] lives,
  output logic       reset_level
);

  localparam int unsigned X_W = 5;
  localparam int unsigned Y_W = 4;
  localparam int unsigned L_W = 2;
  localparam int unsigned C_W = (DEATH_CYC > 1) ? $clog2(DEATH_CYC) : 1;

  localparam logic [X_W-1:0] X_START  = X_W'(START_X);
  localparam logic [X_W-1:0] X_MAX    = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_START  = Y_W'(GRID_H - 1);
  localparam logic [L_W-1:0] L_RESET  = L_W'(LIVES_INIT);
  localparam logic [C_W-1:0] CNT_LAST = C_W'(DEATH_CYC - 1);

  typedef enum logic [1:0] {
    ALIVE     = 2'd0,
    AT_TOP    = 2'd1,
    DYING     = 2'd2,
    GAME_OVER = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           top_q, top_d;
  logic [L_W-1:0] lives_q, lives_d;
  logic           rl_q, rl_d;
  logic [C_W-1:0] cnt_q, cnt_d;
  logic [3:0]     prev_q, prev_d;

  logic [3:0]     sw;
  logic [3:0]     rise;
  logic           step;
  logic [X_W-1:0] mv_x;
  logic [Y_W-1:0] mv_y;

  // Switch bit order: {up, down, left, right}
  assign sw   = {move_up, move_down, move_left, move_right};
  assign rise = sw & ~prev_q;
  // Exactly one rising switch; simultaneous rises are discarded
  assign step = (rise != 4'd0) && ((rise & (rise - 4'd1)) == 4'd0);

  // Target position for a single step, clamped (or wrapped in x)
  always_comb begin
    mv_x = x_q;
    mv_y = y_q;
    if (rise[3]) begin
      mv_y = (y_q == '0) ? y_q : y_q - 1'b1;
    end else if (rise[2]) begin
      mv_y = (y_q == Y_START) ? y_q : y_q + 1'b1;
    end else if (rise[1]) begin
`ifdef FROG_WRAP_EN
      mv_x = (x_q == '0) ? X_MAX : x_q - 1'b1;
`else
      mv_x = (x_q == '0) ? x_q : x_q - 1'b1;
`endif
    end else if (rise[0]) begin
`ifdef FROG_WRAP_EN
      mv_x = (x_q == X_MAX) ? '0 : x_q + 1'b1;
`else
      mv_x = (x_q == X_MAX) ? x_q : x_q + 1'b1;
`endif
    end
  end

  // Next-state logic; priority reset_lives > reset_frog > collision > move
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    top_d   = top_q;
    lives_d = lives_q;
    rl_d    = rl_q;
    cnt_d   = cnt_q;
    prev_d  = sw;

    // The death timer advances regardless of the requests handled below
    if (state_q == DYING) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        state_d = ALIVE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (reset_lives) begin
      lives_d = L_RESET;
      if (state_q == GAME_OVER) begin
        x_d     = X_START;
        y_d     = Y_START;
        rl_d    = 1'b0;
        state_d = ALIVE;
      end
    end else if (reset_frog) begin
      x_d   = X_START;
      y_d   = Y_START;
      top_d = 1'b0;
      if (state_q == AT_TOP) begin
        state_d = ALIVE;
      end else if (state_q == DYING) begin
        cnt_d   = '0;
        state_d = DYING;
      end
    end else if (state_q == ALIVE) begin
      if (collision) begin
        if (lives_q > L_W'(1)) begin
          lives_d = lives_q - 1'b1;
          x_d     = X_START;
          y_d     = Y_START;
          cnt_d   = '0;
          state_d = DYING;
        end else begin
          lives_d = '0;
          rl_d    = 1'b1;
          state_d = GAME_OVER;
        end
      end else if (step) begin
        x_d = mv_x;
        y_d = mv_y;
        if (mv_y == '0) begin
          top_d   = 1'b1;
          state_d = AT_TOP;
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ALIVE;
      x_q     <= X_START;
      y_q     <= Y_START;
      top_q   <= 1'b0;
      lives_q <= L_RESET;
      rl_q    <= 1'b0;
      cnt_q   <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      top_q   <= top_d;
      lives_q <= lives_d;
      rl_q    <= rl_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
    end
  end

  assign frog_x      = x_q;
  assign frog_y      = y_q;
  assign frog_at_top = top_q;
  assign lives       = lives_q;
  assign reset_level = rl_q;

endmodule

// File: tb/tb_frog_controller.sv
// Scoreboard bench for frog_controller: a driver issues per-cycle stimulus and
// pushes the reference model's expected outputs; a monitor pops and compares.
module tb_frog_controller;

  localparam int GRID_W     = 20;
  localparam int GRID_H     = 15;
  localparam int START_X    = 10;
  localparam int LIVES_INIT = 3;
  localparam int DEATH_CYC  = 4;

  typedef struct packed {
    logic [4:0] x;
    logic [3:0] y;
    logic       top;
    logic [1:0] lives;
    logic       rl;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       move_up = 1'b0, move_down = 1'b0, move_left = 1'b0, move_right = 1'b0;
  logic       collision = 1'b0, reset_frog = 1'b0, reset_lives = 1'b0;
  logic [4:0] frog_x;
  logic [3:0] frog_y;
  logic       frog_at_top;
  logic [1:0] lives;
  logic       reset_level;

  frog_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .move_up     (move_up),
    .move_down   (move_down),
    .move_left   (move_left),
    .move_right  (move_right),
    .collision   (collision),
    .reset_frog  (reset_frog),
    .reset_lives (reset_lives),
    .frog_x      (frog_x),
    .frog_y      (frog_y),
    .frog_at_top (frog_at_top),
    .lives       (lives),
    .reset_level (reset_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  obs_t exp_q[$];

  // Reference model: game rules tracked with plain integers
  localparam int M_ALIVE = 0, M_TOP = 1, M_DYING = 2, M_OVER = 3;
  int m_x, m_y, m_lives, m_phase, m_left;
  bit m_top, m_rl;
  logic [3:0] m_prev;

  function automatic obs_t observed();
    obs_t o;
    o.x = frog_x; o.y = frog_y; o.top = frog_at_top; o.lives = lives; o.rl = reset_level;
    return o;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.x = 5'(m_x); o.y = 4'(m_y); o.top = m_top; o.lives = 2'(m_lives); o.rl = m_rl;
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got x=%0d y=%0d top=%0d lives=%0d rl=%0d want x=%0d y=%0d top=%0d lives=%0d rl=%0d",
               name, $time, got.x, got.y, got.top, got.lives, got.rl,
               want.x, want.y, want.top, want.lives, want.rl);
    end
  endtask

  function automatic void model_reset();
    m_x = START_X; m_y = GRID_H - 1; m_lives = LIVES_INIT;
    m_phase = M_ALIVE; m_left = 0; m_top = 0; m_rl = 0; m_prev = 4'b0;
  endfunction

  function automatic void to_start();
    m_x = START_X; m_y = GRID_H - 1;
  endfunction

  function automatic void dying_tick();
    m_left--;
    if (m_left == 0) m_phase = M_ALIVE;
  endfunction

  // sw = {up, down, left, right}
  function automatic void model_step(input logic [3:0] sw, input bit col, input bit rf, input bit rl);
    logic [3:0] rise;
    int nx, ny;
    rise = sw & ~m_prev;
    m_prev = sw;
    if (rl) begin
      m_lives = LIVES_INIT;
      if (m_phase == M_OVER) begin
        to_start(); m_rl = 0; m_phase = M_ALIVE;
      end else if (m_phase == M_DYING) begin
        dying_tick();
      end
    end else if (rf) begin
      to_start(); m_top = 0;
      if (m_phase == M_TOP) m_phase = M_ALIVE;
      else if (m_phase == M_DYING) m_left = DEATH_CYC;
    end else if (m_phase == M_ALIVE) begin
      if (col) begin
        if (m_lives > 1) begin
          m_lives--; to_start(); m_phase = M_DYING; m_left = DEATH_CYC;
        end else begin
          m_lives = 0; m_rl = 1; m_phase = M_OVER;
        end
      end else if ($countones(rise) == 1) begin
        nx = m_x; ny = m_y;
        if (rise[3]) ny--;
        else if (rise[2]) ny++;
        else if (rise[1]) nx--;
        else nx++;
        if (ny < 0) ny = 0;
        if (ny > GRID_H - 1) ny = GRID_H - 1;
`ifdef FROG_WRAP_EN
        if (nx < 0) nx = GRID_W - 1;
        if (nx > GRID_W - 1) nx = 0;
`else
        if (nx < 0) nx = 0;
        if (nx > GRID_W - 1) nx = GRID_W - 1;
`endif
        m_x = nx; m_y = ny;
        if (ny == 0) begin m_top = 1; m_phase = M_TOP; end
      end
    end else if (m_phase == M_DYING) begin
      dying_tick();
    end
  endfunction

  // Driver: one clock of stimulus, expectation pushed for the coming edge
  task automatic drive(input logic [3:0] sw, input bit col = 0, input bit rf = 0, input bit rl = 0);
    @(negedge clk);
    {move_up, move_down, move_left, move_right} = sw;
    collision = col; reset_frog = rf; reset_lives = rl;
    model_step(sw, col, rf, rl);
    exp_q.push_back(model_obs());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(4'b0000);
  endtask

  // Reset asserted on a falling edge; outputs must change without a clock
  task automatic apply_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    {move_up, move_down, move_left, move_right} = 4'b0;
    collision = 0; reset_frog = 0; reset_lives = 0;
    model_reset();
    #1;
    check(name, observed(), model_obs());
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare after every active edge while expectations are pending
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) check("cycle", observed(), exp_q.pop_front());
  end

  initial begin
    obs_t want;
    logic [3:0] sw;
    model_reset();

    apply_reset("reset_state");

    // Walk to the top row, then respawn
    for (int i = 0; i < GRID_H - 1; i++) begin
      drive(4'b1000);
      drive(4'b0000);
    end
    drive(4'b1000);              // moves ignored at top
    drive(4'b0000, 1'b1);        // collision ignored at top
    drive(4'b0000, 1'b0, 1'b1);
    idle(1);

    // Left border and bottom border
    for (int i = 0; i < START_X + 1; i++) begin
      drive(4'b0010);
      drive(4'b0000);
    end
    drive(4'b0100);
    drive(4'b0000);
    drive(4'b0001);
    drive(4'b0000);

    // Collision, then moves blocked for the death period
    drive(4'b0000, 1'b1);
    drive(4'b1000);
    drive(4'b0000);
    drive(4'b1000);
    drive(4'b0000);
    drive(4'b1000);

    // Lose all lives, moves blocked in game over, then restore
    idle(2);
    drive(4'b0000, 1'b1);
    idle(DEATH_CYC + 1);
    drive(4'b0000, 1'b1);
    drive(4'b1000);
    drive(4'b0000);
    drive(4'b0000, 1'b1);
    drive(4'b0000, 1'b0, 1'b1);
    drive(4'b0000, 1'b0, 1'b0, 1'b1);
    idle(1);

    // Simultaneous rises are discarded
    drive(4'b1010);
    drive(4'b0000);
    drive(4'b1111);
    drive(4'b0000);
    drive(4'b1000);
    drive(4'b0000);

    // Async reset in the middle of a death period with one life left
    drive(4'b0000, 1'b1);
    idle(DEATH_CYC + 1);
    drive(4'b0000, 1'b1);
    idle(2);
    @(posedge clk);
    #2;
    want.x = 5'(START_X); want.y = 4'(GRID_H - 1); want.top = 0; want.lives = 2'(1); want.rl = 0;
    check("mid_dying_pre_reset", observed(), want);
    apply_reset("mid_dying_reset");
    drive(4'b1000);              // timer cleared: first rise moves
    drive(4'b0000);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: sw = 4'b0000;
        3:       sw = 4'($urandom);
        default: sw = 4'b0001 << $urandom_range(0, 3);
      endcase
      drive(sw, $urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 39) == 0);
    end
    idle(2);
    @(posedge clk);
    #3;

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
